multdiv: RTL and testbench
==========================

# multdiv

Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage. It accepts a one-cycle start pulse with two operands, iterates internally, and produces a 32-bit result, an exception flag and a one-cycle ready strobe. The result is captured by the downstream 32-bit pipeline latch (enable = `data_resultRDY`), and the pipeline stalls while `busy` is high.

## Interface
- No parameters. Operand and result width is fixed at 32.
- `clock` in 1: single clock. All state changes on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `data_operandA` in 32: multiplicand / dividend, two's complement.
- `data_operandB` in 32: multiplier / divisor, two's complement.
- `ctrl_MULT` in 1: start-multiply pulse. Operands are sampled on the same edge.
- `ctrl_DIV` in 1: start-divide pulse. Operands are sampled on the same edge.
- `data_result` out 32: product low word or quotient. Held until the next start.
- `data_exception` out 1: overflow or divide error for the current result. Held with `data_result`.
- `data_resultRDY` out 1: high for exactly one cycle when the result is valid.
- `busy` out 1: high while an operation is in progress.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **Start:** an edge with `ctrl_MULT`=1 or `ctrl_DIV`=1, in any state, latches both operands and clears the iteration counter. It then enters MUL or DIV. If both are high, MUL wins.
- **Restart while busy:** the in-flight operation is abandoned silently. No `data_resultRDY` is produced for it.
- **Multiply:** Booth recoding over an accumulator {P_hi, P_lo, guard bit}. Each step adds 0, ±A or ±2A and arithmetic-shifts right. The 64-bit signed product is formed internally.
  - `data_result` = product[31:0].
  - `data_exception` = 1 unless product[63:31] are all equal, i.e. the product does not fit in 32 signed bits.
- **Divide:** the operands' magnitudes are taken first, then 32 steps of restoring division, then a sign fixup. The quotient is truncated toward zero and the remainder is discarded.
  - Divisor = 0 → `data_result` = 0, `data_exception` = 1.
  - 0x80000000 / -1 → `data_result` = 0x80000000, `data_exception` = 1.
  - Every other divide → `data_exception` = 0.
- **Completion:** from DONE the unit returns to IDLE on the next edge, unless a start is present on that edge.
- `busy` = 1 in MUL and DIV, and 0 otherwise.

## Timing
- **Reset values:** state = IDLE, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
- **`clr` priority:** `clr` overrides any start in the same cycle. Asserting `clr` mid-operation returns the unit to IDLE with no ready strobe.
- **Latency:** define start edge = E. `data_result`, `data_exception` and `data_resultRDY` update on edge E+L.
  - Multiply: L = 17 (radix-4) or 33 (radix-2); see Configuration.
  - Divide: L = 34 (32 iterations + 1 setup + 1 sign fixup), including divide-by-zero. The zero check does not short-circuit.
- `data_resultRDY` is high only during cycle [E+L, E+L+1).
- `busy` rises on edge E and falls on edge E+L.
- Start pulses need not be one cycle long. Holding `ctrl_*` high restarts the operation on every edge, so no result is ever delivered.
- Operands may change freely after edge E.

## Configuration
- Macro: `MULTDIV_RADIX4_EN`.
- **Defined:** radix-4 modified Booth. Each step examines 3 multiplier bits, selects from {0, ±A, ±2A}, and shifts the accumulator by 2. This takes 16 iterations, so multiply L = 17.
- **Undefined:** radix-2 Booth. Each step examines 2 bits, selects from {0, ±A}, and shifts by 1. This takes 32 iterations, so multiply L = 33.
- Divide behaviour and every interface signal are identical in both builds.

## Test plan
- **Reset:** hold `clr` for 2 cycles, then release. All outputs are 0 and stay 0 with no start.
- **Multiply:** A = 7, B = -6, `ctrl_MULT` pulse.
  - Result 0xFFFFFFD6 with exception 0.
  - `data_resultRDY` high exactly one cycle, at E+17 (radix-4) or E+33 (radix-2).
- **Multiply overflow:** A = 0x00010000, B = 0x00010000 → result 0x00000000, exception 1.
- **Divide:** A = -7, B = 2 → result 0xFFFFFFFD at E+34, exception 0.
- **Divide errors:**
  - A = 5, B = 0 → result 0, exception 1 at E+34.
  - A = 0x80000000, B = -1 → result 0x80000000, exception 1.
- **Restart and reset:**
  - Start DIV of 100/3; at E+10 pulse MULT with A = 3, B = 4. Only one strobe occurs, at E+10+L_mult, with result 12. No strobe occurs for the divide.
  - Separately, assert `clr` at E+5 of a multiply: no strobe follows.

Source files
------------

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute stage and the multdiv unit.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv.sv
// Multi-cycle signed 32-bit Booth multiply / restoring divide.
// Define MULTDIV_RADIX4_EN for radix-4 Booth (16 steps); default is radix-2 (32 steps).
module multdiv (
    input logic      clock,
    input logic      clr,
    multdiv_if.slave bus
);

`ifdef MULTDIV_RADIX4_EN
    localparam int unsigned MulSteps = 16;
    localparam int unsigned MulShift = 2;
`else
    localparam int unsigned MulSteps = 32;
    localparam int unsigned MulShift = 1;
`endif
    localparam logic [5:0] DivLast = 6'd33;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_a, r_b;
    logic [33:0] r_hi;
    logic [31:0] r_lo;
    logic        r_g;
    logic [5:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_start;
    logic        w_mul_last;
    logic [33:0] w_a_ext, w_addend, w_sum;
    logic [66:0] w_shifted;
    logic [34:0] w_prod_top;
    logic        w_mul_exc;
    logic [31:0] w_dvs_mag, w_dvd_mag;
    logic [32:0] w_rem_sh, w_rem_new;
    logic        w_rem_ge;
    logic        w_div_zero, w_div_ovf;
    logic [31:0] w_quot;

    assign w_start    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_mul_last = (r_cnt == 6'(MulSteps));

    // Booth step: accumulator {hi, lo, guard}; hi has two spare bits so +-2A never wraps.
    assign w_a_ext = {{2{r_a[31]}}, r_a};
    always_comb begin
        w_addend = '0;
`ifdef MULTDIV_RADIX4_EN
        case ({r_lo[1:0], r_g})
            3'b001, 3'b010: w_addend = w_a_ext;
            3'b011:         w_addend = w_a_ext << 1;
            3'b100:         w_addend = 34'd0 - (w_a_ext << 1);
            3'b101, 3'b110: w_addend = 34'd0 - w_a_ext;
            default:        w_addend = '0;
        endcase
`else
        case ({r_lo[0], r_g})
            2'b01:   w_addend = w_a_ext;
            2'b10:   w_addend = 34'd0 - w_a_ext;
            default: w_addend = '0;
        endcase
`endif
    end
    assign w_sum      = r_hi + w_addend;
    assign w_shifted  = $signed({w_sum, r_lo, r_g}) >>> MulShift;
    assign w_prod_top = {r_hi, r_lo[31]};
    assign w_mul_exc  = !((&w_prod_top) | ~(|w_prod_top));

    // Restoring divide on magnitudes; r_hi holds the remainder, r_lo shifts dividend -> quotient.
    assign w_dvs_mag  = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_dvd_mag  = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_rem_sh   = {r_hi[31:0], r_lo[31]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, w_dvs_mag});
    assign w_rem_new  = w_rem_ge ? (w_rem_sh - {1'b0, w_dvs_mag}) : w_rem_sh;
    assign w_div_zero = (r_b == 32'd0);
    assign w_div_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_quot     = (r_a[31] ^ r_b[31]) ? (32'd0 - r_lo) : r_lo;

    always_comb begin
        w_state_next = r_state;
        if (bus.ctrl_MULT) begin
            w_state_next = StMul;
        end else if (bus.ctrl_DIV) begin
            w_state_next = StDiv;
        end else begin
            case (r_state)
                StMul:   if (w_mul_last) w_state_next = StDone;
                StDiv:   if (r_cnt == DivLast) w_state_next = StDone;
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clr) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_g      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_a   <= bus.data_operandA;
            r_b   <= bus.data_operandB;
            r_hi  <= '0;
            r_lo  <= bus.data_operandB;
            r_g   <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                StMul: begin
                    if (w_mul_last) begin
                        r_result <= r_lo;
                        r_exc    <= w_mul_exc;
                    end else begin
                        {r_hi, r_lo, r_g} <= w_shifted;
                        r_cnt             <= r_cnt + 6'd1;
                    end
                end
                StDiv: begin
                    if (r_cnt == 6'd0) begin
                        r_hi  <= '0;
                        r_lo  <= w_dvd_mag;
                        r_cnt <= r_cnt + 6'd1;
                    end else if (r_cnt == DivLast) begin
                        r_result <= w_div_zero ? 32'd0 : w_quot;
                        r_exc    <= w_div_zero | w_div_ovf;
                    end else begin
                        r_hi  <= {1'b0, w_rem_new};
                        r_lo  <= {r_lo[30:0], w_rem_ge};
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = (r_state == StDone);
    assign bus.busy           = (r_state == StMul) || (r_state == StDiv);

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: latency, strobe count, results, restart and reset.
module tb_multdiv;

`ifdef MULTDIV_RADIX4_EN
    localparam int LatMul = 17;
`else
    localparam int LatMul = 33;
`endif
    localparam int LatDiv = 34;

    logic clock = 1'b0;
    logic clr   = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    multdiv_if bus ();

    multdiv u_dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one start pulse, then watch a bounded window for strobes.
    task automatic run_op(input string tag, input bit is_mul, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_exc);
        int lat;
        int rdy_at;
        int rdy_cnt;
        logic [31:0] res;
        logic exc;
        lat     = is_mul ? LatMul : LatDiv;
        rdy_at  = 0;
        rdy_cnt = 0;
        res     = 32'hDEAD_BEEF;
        exc     = 1'bx;
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = is_mul;
        bus.ctrl_DIV      = !is_mul;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = ~a;
        bus.data_operandB = a ^ b;
        check_eq({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge clock);
            #1;
            if (k == lat) check_eq({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
            if (bus.data_resultRDY) begin
                rdy_cnt++;
                if (rdy_at == 0) begin
                    rdy_at = k;
                    res    = bus.data_result;
                    exc    = bus.data_exception;
                end
            end
        end
        check_eq({tag, "_lat"}, 32'(rdy_at), 32'(lat));
        check_eq({tag, "_nrdy"}, 32'(rdy_cnt), 32'd1);
        check_eq({tag, "_res"}, res, exp_res);
        check_eq({tag, "_exc"}, 32'(exc), 32'(exp_exc));
    endtask

    initial begin
        int rdy_at;
        int rdy_cnt;
        logic [31:0] res;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;

        // Reset
        repeat (2) @(posedge clock);
        #1;
        clr = 1'b0;
        check_eq("rst_res", bus.data_result, 32'd0);
        check_eq("rst_exc", 32'(bus.data_exception), 32'd0);
        check_eq("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("idle_rdy", 32'(bus.data_resultRDY), 32'd0);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        // Multiply
        run_op("mul_7xm6", 1'b1, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("mul_minxm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("mul_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        run_op("mul_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0);

        // Divide
        run_op("div_m7d2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("div_5d0", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1);
        run_op("div_mindm1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("div_100dm7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        run_op("div_m100dm7", 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);

        // Restart: DIV 100/3 abandoned by MULT 3*4 sampled at E+10
        @(negedge clock);
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd3;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        rdy_at  = 0;
        rdy_cnt = 0;
        res     = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) begin
                rdy_cnt++;
                if (rdy_at == 0) begin
                    rdy_at = k;
                    res    = bus.data_result;
                end
            end
        end
        check_eq("restart_lat", 32'(rdy_at), 32'(LatMul));
        check_eq("restart_nrdy", 32'(rdy_cnt), 32'd1);
        check_eq("restart_res", res, 32'd12);

        // clr at E+5 of a multiply
        @(negedge clock);
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        clr = 1'b1;
        @(posedge clock);
        #1;
        clr = 1'b0;
        check_eq("clr_busy", 32'(bus.busy), 32'd0);
        check_eq("clr_res", bus.data_result, 32'd0);
        rdy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) rdy_cnt++;
        end
        check_eq("clr_nrdy", 32'(rdy_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
